// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that packs consecutive bytes, least-significant byte first,
// into a DATA_WIDTH-bit word and strobes each completed word for one cycle.
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic                  RxD,
  output logic [DATA_WIDTH-1:0] Word,
  output logic                  Strobe,
  output logic                  FrameErr,
  output logic                  Busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic [1:0]            sync_r;
  logic                  rx_s;
  state_t                state_r;
  state_t                state_nx_s;
  logic [CW-1:0]         bit_cnt_r;
  logic [2:0]            bit_idx_r;
  logic [7:0]            shift_r;
  logic [BW-1:0]         byte_cnt_r;
  logic [DATA_WIDTH-1:0] word_acc_r;
  logic [DATA_WIDTH-1:0] acc_nx_s;
  logic                  half_s;
  logic                  last_s;
  logic                  data_smp_s;
  logic                  byte_ok_s;
  logic                  word_done_s;
  logic                  frame_bad_s;

  assign rx_s   = sync_r[1];
  assign half_s = (bit_cnt_r == CNT_HALF);
  assign last_s = (bit_cnt_r == CNT_LAST);

  // Two-flop synchronizer; idles high so Clear never fakes a start bit.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], RxD};
    end
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; STOP leaves at mid-bit so a following start edge is caught.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) state_nx_s = ST_START;
        else       state_nx_s = ST_IDLE;
      end
      ST_START: begin
        if (half_s) state_nx_s = rx_s ? ST_IDLE : ST_DATA;
        else        state_nx_s = ST_START;
      end
      ST_DATA: begin
        if (last_s && (bit_idx_r == 3'd7)) state_nx_s = ST_STOP;
        else                               state_nx_s = ST_DATA;
      end
      ST_STOP: begin
        if (last_s) state_nx_s = rx_s ? ST_IDLE : ST_BREAK;
        else        state_nx_s = ST_STOP;
      end
      ST_BREAK: begin
        if (rx_s) state_nx_s = ST_IDLE;
        else      state_nx_s = ST_BREAK;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Output decode: sampling events and the accumulator with the current byte merged in.
  always_comb begin
    data_smp_s  = 1'b0;
    byte_ok_s   = 1'b0;
    frame_bad_s = 1'b0;
    word_done_s = 1'b0;
    acc_nx_s    = word_acc_r;
    acc_nx_s[{byte_cnt_r, 3'b000} +: 8] = shift_r;
    case (state_r)
      ST_DATA: begin
        data_smp_s = last_s;
      end
      ST_STOP: begin
        byte_ok_s   = last_s & rx_s;
        frame_bad_s = last_s & ~rx_s;
        word_done_s = last_s & rx_s & (byte_cnt_r == BYTE_LAST);
      end
      default: begin
        data_smp_s = 1'b0;
      end
    endcase
  end

  // Per-bit timing counter, restarted on every state change.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      bit_cnt_r <= {CW{1'b0}};
    end else if ((state_nx_s != state_r) || last_s) begin
      bit_cnt_r <= {CW{1'b0}};
    end else begin
      bit_cnt_r <= bit_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Data bit capture; the index wraps back to 0 after bit 7.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else if (data_smp_s) begin
      bit_idx_r          <= bit_idx_r + 3'd1;
      shift_r[bit_idx_r] <= rx_s;
    end else begin
      bit_idx_r <= bit_idx_r;
      shift_r   <= shift_r;
    end
  end

  // Word assembly; a framing error throws away the partial word.
  always_ff @(posedge Clock) begin
    if (Clear || frame_bad_s) begin
      byte_cnt_r <= {BW{1'b0}};
      word_acc_r <= {DATA_WIDTH{1'b0}};
    end else if (word_done_s) begin
      byte_cnt_r <= {BW{1'b0}};
      word_acc_r <= acc_nx_s;
    end else if (byte_ok_s) begin
      byte_cnt_r <= byte_cnt_r + {{(BW-1){1'b0}}, 1'b1};
      word_acc_r <= acc_nx_s;
    end else begin
      byte_cnt_r <= byte_cnt_r;
      word_acc_r <= word_acc_r;
    end
  end

  // Registered outputs; Busy follows the state being entered.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      Word     <= {DATA_WIDTH{1'b0}};
      Strobe   <= 1'b0;
      FrameErr <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      Word     <= word_done_s ? acc_nx_s : Word;
      Strobe   <= word_done_s;
      FrameErr <= frame_bad_s;
      Busy     <= (state_nx_s != ST_IDLE);
    end
  end

endmodule
